truth_table_sweeper: RTL and testbench

- Hardware stimulus-and-check stage that sits directly upstream of the 4-input boolean expression block (inputs a, b, c, d; outputs y1..y5).
- Replaces the hand-written 16-step testbench sequence with synthesizable logic:
  - walks all 16 input combinations in order 0000..1111 on {a,b,c,d};
  - waits a settle interval, then samples the five outputs;
  - stores each sample and compares it against a loadable expected truth table;
  - reports pass/fail, error count and the first failing vector.

---
 rtl/truth_table_sweeper_if.sv | 35 +++
 rtl/truth_table_sweeper.sv | 118 +++++++++++
 tb/tb_truth_table_sweeper.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/truth_table_sweeper_if.sv
// Bus between the truth-table sweeper and its host/observed block.
// The slave modport is the sweeper's view; master is the host/bench view.
interface truth_table_sweeper_if #(
  parameter int NUM_OUT = 5
) ();
  logic               start;
  logic               a;
  logic               b;
  logic               c;
  logic               d;
  logic [NUM_OUT-1:0] y_in;
  logic               exp_we;
  logic [3:0]         exp_addr;
  logic [NUM_OUT-1:0] exp_data;
  logic [3:0]         rd_addr;
  logic [NUM_OUT-1:0] rd_data;
  logic               busy;
  logic               done;
  logic               pass;
  logic [4:0]         err_count;
  logic [3:0]         first_err_vec;
  logic               first_err_valid;

  modport slave (
    input  start, y_in, exp_we, exp_addr, exp_data, rd_addr,
    output a, b, c, d, rd_data, busy, done, pass, err_count,
           first_err_vec, first_err_valid
  );

  modport master (
    output start, y_in, exp_we, exp_addr, exp_data, rd_addr,
    input  a, b, c, d, rd_data, busy, done, pass, err_count,
           first_err_vec, first_err_valid
  );
endinterface

// File: rtl/truth_table_sweeper.sv
// Walks all 16 {a,b,c,d} combinations, samples y_in after a settle interval
// and checks each sample against a loadable expected truth table.
//
// state   | meaning
// IDLE    | waiting for start, abcd = 0000
// DRIVE   | vec held on abcd while the settle counter runs
// CAPTURE | one cycle: store y_in, compare with expected, advance vec
// DONE    | sweep finished, status held, abcd = 1111
module truth_table_sweeper #(
  parameter int SETTLE_CYCLES = 2,
  parameter int NUM_OUT       = 5
) (
  input logic                  clk,
  input logic                  rst,
  truth_table_sweeper_if.slave bus
);

  typedef enum logic [1:0] {IDLE, DRIVE, CAPTURE, DONE} state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_t             state;
  state_t             state_next;
  logic [3:0]         vec;
  logic [3:0]         settle_cnt;
  logic [NUM_OUT-1:0] exp_tbl [16];
  logic [NUM_OUT-1:0] result  [16];
  logic [4:0]         err_count;
  logic [3:0]         first_err_vec;
  logic               first_err_valid;
  logic               settle_tc;
  logic               launch;
  logic               capture;
  logic               mismatch;
  logic               busy;

  assign settle_tc = (settle_cnt == SETTLE_LAST);
  assign busy      = (state == DRIVE) || (state == CAPTURE);
  assign mismatch  = (bus.y_in != exp_tbl[vec]);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    launch     = 1'b0;
    capture    = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          state_next = DRIVE;
          launch     = 1'b1;
        end
      end
      DRIVE: begin
        if (settle_tc) state_next = CAPTURE;
      end
      CAPTURE: begin
        capture    = 1'b1;
        state_next = (vec == 4'd15) ? DONE : DRIVE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vec             <= 4'd0;
      settle_cnt      <= 4'd0;
      err_count       <= 5'd0;
      first_err_vec   <= 4'd0;
      first_err_valid <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        exp_tbl[i] <= '0;
        result[i]  <= '0;
      end
    end else begin
      if (launch) begin
        vec             <= 4'd0;
        settle_cnt      <= 4'd0;
        err_count       <= 5'd0;
        first_err_vec   <= 4'd0;
        first_err_valid <= 1'b0;
      end else if (state == DRIVE) begin
        settle_cnt <= settle_tc ? 4'd0 : settle_cnt + 4'd1;
      end else if (capture) begin
        result[vec] <= bus.y_in;
        if (mismatch) begin
          err_count <= err_count + 5'd1;
          if (!first_err_valid) begin
            first_err_vec   <= vec;
            first_err_valid <= 1'b1;
          end
        end
        // vec stays at 15 in DONE so abcd reads 1111
        if (vec != 4'd15) vec <= vec + 4'd1;
        settle_cnt <= 4'd0;
      end
      // table is frozen during a sweep so every vector sees the same expectations
      if (bus.exp_we && !busy) exp_tbl[bus.exp_addr] <= bus.exp_data;
    end
  end

  assign bus.a               = vec[3];
  assign bus.b               = vec[2];
  assign bus.c               = vec[1];
  assign bus.d               = vec[0];
  assign bus.rd_data         = result[bus.rd_addr];
  assign bus.busy            = busy;
  assign bus.done            = (state == DONE);
  assign bus.pass            = (state == DONE) && (err_count == 5'd0);
  assign bus.err_count       = err_count;
  assign bus.first_err_vec   = first_err_vec;
  assign bus.first_err_valid = first_err_valid;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Randomized bench for truth_table_sweeper: y_in comes from a random lookup
// table indexed by abcd, and sweep outcomes are predicted from table contents.
module tb_truth_table_sweeper;

  localparam int S   = 2;
  localparam int PER = S + 1;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  logic [4:0] lut   [16];
  logic [4:0] exp_m [16];

  truth_table_sweeper_if #(.NUM_OUT(5)) u_if ();
  truth_table_sweeper_if #(.NUM_OUT(5)) u_if1 ();

  truth_table_sweeper #(.SETTLE_CYCLES(S), .NUM_OUT(5)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if.slave)
  );

  truth_table_sweeper #(.SETTLE_CYCLES(1), .NUM_OUT(5)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (u_if1.slave)
  );

  always #5 clk = ~clk;

  always_comb u_if.y_in = lut[{u_if.a, u_if.b, u_if.c, u_if.d}];
  assign u_if1.y_in = 5'd0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  task automatic load_table();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      u_if.exp_we   = 1'b1;
      u_if.exp_addr = 4'(i);
      u_if.exp_data = exp_m[i];
    end
    @(negedge clk);
    u_if.exp_we = 1'b0;
  endtask

  task automatic check_rd(input bit zeros);
    for (int i = 0; i < 16; i++) begin
      u_if.rd_addr = 4'(i);
      #1;
      chk("rd_data", u_if.rd_data, zeros ? 5'd0 : lut[i]);
    end
  endtask

  task automatic check_status();
    int  nerr = 0;
    int  first = 0;
    bit  fv = 1'b0;
    for (int i = 0; i < 16; i++)
      if (lut[i] != exp_m[i]) begin
        nerr++;
        if (!fv) begin first = i; fv = 1'b1; end
      end
    chk("done",      u_if.done, 1);
    chk("busy_done", u_if.busy, 0);
    chk("abcd_done", {u_if.a, u_if.b, u_if.c, u_if.d}, 15);
    chk("pass",      u_if.pass, (nerr == 0) ? 1 : 0);
    chk("err_count", u_if.err_count, nerr);
    chk("fe_valid",  u_if.first_err_valid, fv);
    chk("fe_vec",    u_if.first_err_vec, first);
    check_rd(1'b0);
  endtask

  task automatic run_sweep(input bit inject, input bit wr0, input logic [4:0] wr0_data);
    int k;
    @(negedge clk);
    u_if.start = 1'b1;
    if (wr0) begin
      u_if.exp_we   = 1'b1;
      u_if.exp_addr = 4'd0;
      u_if.exp_data = wr0_data;
      exp_m[0]      = wr0_data;
    end
    @(negedge clk);
    u_if.start  = 1'b0;
    u_if.exp_we = 1'b0;
    k = 0;
    while (u_if.done !== 1'b1 && k < 200) begin
      chk("abcd", {u_if.a, u_if.b, u_if.c, u_if.d}, k / PER);
      chk("busy", u_if.busy, 1);
      if (k == 0) begin
        chk("clr_err",  u_if.err_count, 0);
        chk("clr_fev",  u_if.first_err_valid, 0);
        chk("clr_pass", u_if.pass, 0);
      end
      if (inject && k == 20) begin
        u_if.start    = 1'b1;
        u_if.exp_we   = 1'b1;
        u_if.exp_addr = 4'd3;
        u_if.exp_data = 5'h1f;
      end
      @(negedge clk);
      u_if.start  = 1'b0;
      u_if.exp_we = 1'b0;
      k++;
    end
    chk("done_latency", k, 16 * PER);
    check_status();
  endtask

  task automatic rand_tables();
    for (int i = 0; i < 16; i++) begin
      lut[i]   = 5'($urandom_range(0, 31));
      exp_m[i] = ($urandom_range(0, 3) == 0) ? (lut[i] ^ 5'($urandom_range(1, 31))) : lut[i];
    end
  endtask

  initial begin
    int k;
    rst = 1'b1;
    u_if.start = 1'b0; u_if.exp_we = 1'b0; u_if.exp_addr = '0;
    u_if.exp_data = '0; u_if.rd_addr = '0;
    u_if1.start = 1'b0; u_if1.exp_we = 1'b0; u_if1.exp_addr = '0;
    u_if1.exp_data = '0; u_if1.rd_addr = '0;
    for (int i = 0; i < 16; i++) begin lut[i] = 5'(i); exp_m[i] = 5'(i); end
    repeat (3) @(negedge clk);
    rst = 1'b0;

    chk("rst_abcd", {u_if.a, u_if.b, u_if.c, u_if.d}, 0);
    chk("rst_busy", u_if.busy, 0);
    chk("rst_done", u_if.done, 0);
    chk("rst_pass", u_if.pass, 0);
    chk("rst_err",  u_if.err_count, 0);
    chk("rst_fev",  u_if.first_err_vec, 0);
    chk("rst_fevv", u_if.first_err_valid, 0);
    check_rd(1'b1);

    // loopback, matching table
    load_table();
    run_sweep(1'b0, 1'b0, 5'd0);
    u_if.rd_addr = 4'd9; #1;
    chk("rd9", u_if.rd_data, 5'b01001);

    // two planted expectation errors
    exp_m[5] = 5'h1f; exp_m[12] = 5'h00;
    load_table();
    run_sweep(1'b0, 1'b0, 5'd0);

    // restart from failing DONE with corrected table
    exp_m[5] = 5'd5; exp_m[12] = 5'd12;
    load_table();
    run_sweep(1'b0, 1'b0, 5'd0);

    // mid-sweep start and table write are ignored
    run_sweep(1'b1, 1'b0, 5'd0);

    for (int r = 0; r < 4; r++) begin
      rand_tables();
      load_table();
      run_sweep(1'b0, r == 2, ~lut[0]);
    end

    // reset while vec==7
    @(negedge clk);
    u_if.start = 1'b1;
    @(negedge clk);
    u_if.start = 1'b0;
    repeat (7 * PER) @(negedge clk);
    chk("pre_rst_vec", {u_if.a, u_if.b, u_if.c, u_if.d}, 7);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_abcd", {u_if.a, u_if.b, u_if.c, u_if.d}, 0);
    chk("mid_rst_busy", u_if.busy, 0);
    chk("mid_rst_err",  u_if.err_count, 0);
    chk("mid_rst_fevv", u_if.first_err_valid, 0);
    check_rd(1'b1);
    for (int i = 0; i < 16; i++) exp_m[i] = 5'd0;
    run_sweep(1'b0, 1'b0, 5'd0);

    // SETTLE_CYCLES=1 instance, all zero table and observed outputs
    @(negedge clk);
    u_if1.start = 1'b1;
    @(negedge clk);
    u_if1.start = 1'b0;
    k = 0;
    while (u_if1.done !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("s1_latency", k, 32);
    chk("s1_pass",    u_if1.pass, 1);
    chk("s1_err",     u_if1.err_count, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
